// File: rtl/uart_rx.sv
// UART receiver: 8-bit LSB-first frames with optional even/odd parity and one stop bit.
// Optional build macro UART_RX_SYNC_EN adds a 2-flop RXD synchronizer (+2 cycles latency).
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  input  logic [1:0] PARITY_MODE,
  output logic [7:0] DATA_OUT,
  output logic       VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'((HALF > 0) ? HALF - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic rxd_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], RXD};
  end

  assign rxd_s = sync_q[1];
`else
  assign rxd_s = RXD;
`endif

  state_t          state_q, state_n;
  logic [TW-1:0]   timer_q, timer_n;
  logic [2:0]      bit_cnt_q, bit_cnt_n;
  logic [7:0]      shreg_q, shreg_n;
  logic [1:0]      mode_q, mode_n;
  logic            armed_q, armed_n;
  logic            pmis_q, pmis_n;
  logic [7:0]      data_q, data_n;
  logic            valid_q, valid_n;
  logic            perr_q, perr_n;
  logic            ferr_q, ferr_n;

  logic            tick;
  logic            par_en;

  assign tick   = (timer_q == '0);
  assign par_en = (mode_q == 2'b01) || (mode_q == 2'b10);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      mode_q    <= '0;
      armed_q   <= 1'b0;
      pmis_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      timer_q   <= timer_n;
      bit_cnt_q <= bit_cnt_n;
      shreg_q   <= shreg_n;
      mode_q    <= mode_n;
      armed_q   <= armed_n;
      pmis_q    <= pmis_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      perr_q    <= perr_n;
      ferr_q    <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    timer_n   = timer_q;
    bit_cnt_n = bit_cnt_q;
    shreg_n   = shreg_q;
    mode_n    = mode_q;
    armed_n   = armed_q;
    pmis_n    = pmis_q;
    data_n    = data_q;
    valid_n   = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rxd_s) armed_n = 1'b1;
        // A low line only starts a frame once it has been seen high (break guard).
        if (armed_q && !rxd_s) begin
          mode_n    = PARITY_MODE;
          bit_cnt_n = '0;
          pmis_n    = 1'b0;
          if (HALF == 0) begin
            state_n = S_DATA;
            timer_n = BIT_RELOAD;
          end else begin
            state_n = S_START;
            timer_n = HALF_RELOAD;
          end
        end
      end

      S_START: begin
        if (tick) begin
          if (!rxd_s) begin
            state_n = S_DATA;
            timer_n = BIT_RELOAD;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end

      S_DATA: begin
        if (tick) begin
          shreg_n   = {rxd_s, shreg_q[7:1]};
          bit_cnt_n = bit_cnt_q + 3'd1;
          timer_n   = BIT_RELOAD;
          if (bit_cnt_q == 3'd7) state_n = par_en ? S_PARITY : S_STOP;
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end

      S_PARITY: begin
        if (tick) begin
          // Even wants XOR of data and parity = 0, odd wants 1.
          pmis_n  = (^shreg_q) ^ rxd_s ^ (mode_q == 2'b10);
          timer_n = BIT_RELOAD;
          state_n = S_STOP;
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end

      S_STOP: begin
        if (tick) begin
          data_n  = shreg_q;
          valid_n = 1'b1;
          ferr_n  = ~rxd_s;
          perr_n  = pmis_q & par_en;
          armed_n = 1'b0;
          timer_n = '0;
          state_n = S_IDLE;
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign DATA_OUT   = data_q;
  assign VALID      = valid_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;

endmodule
